uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receive path with an input filter, an RX FIFO and optional echo, all in one clock domain. It succeeds the fixed 8-bit, unbuffered receive/echo wrapper. Sits between the board `RsRx`/`RsTx` pins and downstream consumers such as the text/display writer. Those consumers pull filtered characters through a valid/ready handshake instead of sampling a one-cycle write strobe.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: system clock frequency.
- `BAUD`, 9600: line rate.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `FIFO_DEPTH`, 16: RX FIFO entries; power of two, at least 2.
- `LO`, 'h21: lowest accepted code, inclusive.
- `HI`, 'h7A: highest accepted code, inclusive.

Ports:
- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `RsRx` in 1: serial input, idle high; asynchronous, so it passes through a 2-flop synchroniser.
- `RsTx` out 1: serial output, idle high.
- `rd_data` out DATA_BITS: FIFO head.
- `rd_valid` out 1: FIFO not empty.
- `rd_ready` in 1: consumer accepts the head.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `filt_drop` out 1: one-cycle pulse when a good frame falls outside [LO,HI].
- `overflow` out 1: one-cycle pulse when an accepted byte is lost because the FIFO is full.

## Operation
- **Tick generator:** free-running counter; `DIV = (CLK_HZ + 8*BAUD) / (16*BAUD)` (rounded); emits a one-clk `tick` at 16x baud.
- **RX FSM:** IDLE → START → DATA → STOP → IDLE. All bit timing is counted in ticks.
  - IDLE: a falling edge on the synchronised input → START; tick counter cleared.
  - START: sample at tick 7. Low → DATA. High → false start → IDLE.
  - DATA: sample every 16 ticks; LSB first; DATA_BITS samples → STOP.
  - STOP: sample after 16 ticks. Low → `frame_err` pulse, byte discarded. High → filter.
- **Filter:** unsigned compare `LO <= byte <= HI`.
  - Pass → push.
  - Fail → `filt_drop`, no push.
- **FIFO:** first-word-fall-through.
  - Pointers are log2(FIFO_DEPTH)+1 bits; wrap is natural.
  - Pop when `rd_valid && rd_ready`.
  - Push to a full FIFO → byte dropped, `overflow` pulse. Exception: a pop in the same cycle frees a slot, so push and pop both succeed and the count is unchanged.
  - Simultaneous push and pop when empty: the pop is ignored because `rd_valid` is 0; the push succeeds.
- **Flow control:** the receiver never stalls; the line cannot be back-pressured.

## Timing
- **Reset values:** `RsTx`=1, `rd_valid`=0, `rd_data`=0, all pulses 0, FIFO empty, FSMs IDLE, tick counter 0.
- **Push latency:** push occurs on the clk after the stop-bit sample; `rd_valid` rises one clk after the push.
- **Head update:** `rd_data` changes only on a push into an empty FIFO, or on a pop. It holds while `rd_valid && !rd_ready`.
- **Pulse timing:** `frame_err`, `filt_drop` and `overflow` each last exactly one clk, aligned with the would-be push cycle.
- **Reset mid-frame:** partial RX and TX frames are abandoned; `RsTx` goes high on the next clk; no push.
- **Back-to-back frames:** a start edge is recognised in the same clk the FSM returns to IDLE.

## Configuration
- `UART_ECHO_EN` defined:
  - Every byte pushed into the FIFO is also transmitted on `RsTx`.
  - TX FSM: IDLE → START → DATA → STOP, 16 ticks per bit, with a 1-entry holding register.
  - If the holding register is full when a new echo arrives, the echo is dropped silently. The FIFO push is unaffected.
- `UART_ECHO_EN` undefined: no TX logic is built; `RsTx` is tied to 1.

## Structure
- **Package `uart_pkg`:** RX/TX state enums (`rx_state_t`, `tx_state_t`), the `OVERSAMPLE`=16 constant, and the divisor function.
- **Sub-module `uart_sync_fifo`:** parameters WIDTH and DEPTH; ports push/pop/full/empty/dout. Instantiated once.
- The tick generator and FSMs stay in the top module.

## Test plan
- **Filter pass:** send 'h41 at 9600 8N1 with `rd_ready`=0 → `rd_valid`=1, `rd_data`='h41 one clk after push, no pulses. With echo enabled, `RsTx` replays 'h41.
- **Filter reject:** send 'h20 then 'h7B → two `filt_drop` pulses, `rd_valid` stays 0, `RsTx` stays idle.
- **Overflow:** send 17 × 'h30, no reads, FIFO_DEPTH=16 → the 17th produces an `overflow` pulse. Then 16 pops return 'h30 and `rd_valid` falls.
- **Line errors:**
  - Stop bit forced low → `frame_err` pulse, no push.
  - 3-tick glitch low on idle line → no frame started, no pulses.
- **Full + simultaneous pop:** FIFO full with `rd_ready`=1 held while a byte arrives → push and pop both occur, count stays 16, no `overflow`.
- **Reset mid-frame:** `rst_n`=0 during data bit 4 → all outputs at reset values next clk. The following clean 'h5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive/echo path.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a pop frees a slot for a same-cycle push when full.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= din;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with range filter and RX FIFO; define UART_ECHO_EN to echo accepted bytes on RsTx.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LO         = 'h21,
  parameter int unsigned HI         = 'h7A
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RsRx,
  output logic                 RsTx,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic                 frame_err,
  output logic                 filt_drop,
  output logic                 overflow
);

  localparam int unsigned DIV   = baud_div(CLK_HZ, BAUD);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic [2:0]       sync_q;
  logic             rx_bit, rx_fall;

  rx_state_t            state_q, state_d;
  logic [OS_W-1:0]      tcnt_q, tcnt_d;
  logic [BIT_W-1:0]     bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 push_q, push_d, ferr_q, ferr_d, fdrop_q, fdrop_d;
  logic                 in_range;
  logic                 fifo_full, fifo_empty;

  // Free-running 16x-baud tick
  assign tick = (div_q == DIV_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)    div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + DIV_W'(1);
  end

  // sync_q[1:0] is the synchroniser, sync_q[2] the previous synchronised sample
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 3'b111;
    else        sync_q <= {sync_q[1:0], RsRx};
  end

  assign rx_bit   = sync_q[1];
  assign rx_fall  = sync_q[2] && !sync_q[1];
  assign in_range = (32'(shift_q) >= LO) && (32'(shift_q) <= HI);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
      fdrop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      push_q  <= push_d;
      ferr_q  <= ferr_d;
      fdrop_q <= fdrop_d;
    end
  end

  // Receive FSM; the stop-bit verdict is registered so push and pulses share one cycle
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    push_d  = 1'b0;
    ferr_d  = 1'b0;
    fdrop_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          state_d = RX_START;
          tcnt_d  = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          tcnt_d = tcnt_q + OS_W'(1);
          if (tcnt_q == OS_MID) begin
            state_d = rx_bit ? RX_IDLE : RX_DATA;
            tcnt_d  = '0;
            bcnt_d  = '0;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          tcnt_d = tcnt_q + OS_W'(1);
          if (tcnt_q == OS_LAST) begin
            shift_d = {rx_bit, shift_q[DATA_BITS-1:1]};
            bcnt_d  = bcnt_q + BIT_W'(1);
            if (bcnt_q == BIT_W'(DATA_BITS - 1)) state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          tcnt_d = tcnt_q + OS_W'(1);
          if (tcnt_q == OS_LAST) begin
            state_d = RX_IDLE;
            if (!rx_bit)       ferr_d  = 1'b1;
            else if (in_range) push_d  = 1'b1;
            else               fdrop_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .pop   (rd_ready),
    .din   (shift_q),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (rd_data)
  );

  assign rd_valid  = !fifo_empty;
  assign frame_err = ferr_q;
  assign filt_drop = fdrop_q;
  // A full FIFO is never empty, so rd_ready alone decides whether a slot frees up
  assign overflow  = push_q && fifo_full && !rd_ready;

`ifdef UART_ECHO_EN
  tx_state_t            tx_state_q, tx_state_d;
  logic [OS_W-1:0]      tx_tcnt_q, tx_tcnt_d;
  logic [BIT_W-1:0]     tx_bcnt_q, tx_bcnt_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d, hold_q, hold_d;
  logic                 hold_vld_q, hold_vld_d, tx_q, tx_d;
  logic                 push_ok;

  assign push_ok = push_q && (!fifo_full || rd_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_tcnt_q  <= '0;
      tx_bcnt_q  <= '0;
      tx_shift_q <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bcnt_q  <= tx_bcnt_d;
      tx_shift_q <= tx_shift_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      tx_q       <= tx_d;
    end
  end

  // Echo transmitter fed by a one-entry holding register; echoes arriving while it is full are lost
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bcnt_d  = tx_bcnt_q;
    tx_shift_d = tx_shift_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    tx_d       = 1'b1;
    if (push_ok && !hold_vld_q) begin
      hold_d     = shift_q;
      hold_vld_d = 1'b1;
    end
    case (tx_state_q)
      TX_IDLE: begin
        if (hold_vld_q) begin
          tx_state_d = TX_START;
          tx_shift_d = hold_q;
          hold_vld_d = 1'b0;
          tx_tcnt_d  = '0;
        end
      end
      TX_START: begin
        if (tick) begin
          tx_tcnt_d = tx_tcnt_q + OS_W'(1);
          if (tx_tcnt_q == OS_LAST) begin
            tx_state_d = TX_DATA;
            tx_bcnt_d  = '0;
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          tx_tcnt_d = tx_tcnt_q + OS_W'(1);
          if (tx_tcnt_q == OS_LAST) begin
            tx_shift_d = tx_shift_q >> 1;
            tx_bcnt_d  = tx_bcnt_q + BIT_W'(1);
            if (tx_bcnt_q == BIT_W'(DATA_BITS - 1)) tx_state_d = TX_STOP;
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          tx_tcnt_d = tx_tcnt_q + OS_W'(1);
          if (tx_tcnt_q == OS_LAST) tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign RsTx = tx_q;
`else
  assign RsTx = 1'b1;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 ticks/bit with a 2-clock divider (32 clocks per bit).
module tb_uart_rx_fifo;

  localparam int BIT_CLKS   = 32;
  localparam int FRAME_CLKS = 10 * BIT_CLKS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RsRx = 1'b1;
  logic       rd_ready = 1'b0;
  logic       RsTx;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       frame_err, filt_drop, overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_ferr = 0, n_filt = 0, n_ovf = 0, n_rise = 0;
  int ferr_cyc = 0, filt_cyc = 0, ovf_cyc = 0, rise_cyc = 0;
  logic valid_prev = 1'b0;

  uart_rx_fifo #(
    .CLK_HZ     (3_200_000),
    .BAUD       (100_000),
    .DATA_BITS  (8),
    .FIFO_DEPTH (16),
    .LO         ('h21),
    .HI         ('h7A)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RsRx      (RsRx),
    .RsTx      (RsTx),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .frame_err (frame_err),
    .filt_drop (filt_drop),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release, in step with the DUT's tick divider
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  // Pulse and rd_valid-rise monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (frame_err) begin n_ferr++; ferr_cyc = cyc; end
    if (filt_drop) begin n_filt++; filt_cyc = cyc; end
    if (overflow)  begin n_ovf++;  ovf_cyc  = cyc; end
    if (rd_valid && !valid_prev) begin n_rise++; rise_cyc = cyc; end
    valid_prev = rd_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One 8N1 frame starting on an even cycle; rd_ready pulses at frame offset pop_at (-1: never)
  task automatic send(input logic [7:0] b, input logic stop, input int pop_at, output int f0);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    while (cyc % 2 != 0) step(1);
    f0 = cyc;
    for (int k = 0; k < FRAME_CLKS; k++) begin
      RsRx     = fr[k / BIT_CLKS];
      rd_ready = (k == pop_at);
      step(1);
    end
    RsRx     = 1'b1;
    rd_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rstx"},  32'(RsTx), 32'd1);
    chk({tag, "_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_data"},  32'(rd_data), 32'd0);
    chk({tag, "_ferr"},  32'(frame_err), 32'd0);
    chk({tag, "_fdrop"}, 32'(filt_drop), 32'd0);
    chk({tag, "_ovf"},   32'(overflow), 32'd0);
  endtask

  initial begin
    int f0, p, p2, s_ferr, s_filt, s_ovf, s_rise;
    logic [7:0] partial;

    rst_n = 1'b0;
    step(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step(5);

    // Out-of-range bytes just below LO and just above HI
    s_ferr = n_ferr; s_filt = n_filt; s_ovf = n_ovf;
    send(8'h20, 1'b1, -1, f0);
    p = filt_cyc - f0;
    send(8'h7B, 1'b1, -1, f0);
    p2 = filt_cyc - f0;
    step(8);
    chk("reject_drops", 32'(n_filt - s_filt), 32'd2);
    chk("reject_align", 32'(p2), 32'(p));
    chk("verdict_in_stop_bit", 32'(p >= 9 * BIT_CLKS && p < FRAME_CLKS), 32'd1);
    chk("reject_valid", 32'(rd_valid), 32'd0);
    chk("reject_no_ferr", 32'(n_ferr - s_ferr), 32'd0);
    chk("reject_no_ovf", 32'(n_ovf - s_ovf), 32'd0);
`ifndef UART_ECHO_EN
    chk("reject_tx_idle", 32'(RsTx), 32'd1);
`endif

    // Accepted byte appears one clock after its push cycle and holds without rd_ready
    s_rise = n_rise; s_filt = n_filt;
    send(8'h41, 1'b1, -1, f0);
    step(4);
    chk("pass_rise", 32'(n_rise - s_rise), 32'd1);
    chk("pass_latency", 32'(rise_cyc - f0), 32'(p + 1));
    chk("pass_valid", 32'(rd_valid), 32'd1);
    chk("pass_data", 32'(rd_data), 32'h41);
    chk("pass_no_drop", 32'(n_filt - s_filt), 32'd0);
    step(20);
    chk("pass_hold", 32'(rd_data), 32'h41);
    rd_ready = 1'b1;
    step(1);
    rd_ready = 1'b0;
    chk("pass_popped", 32'(rd_valid), 32'd0);

    // Stop bit low
    s_ferr = n_ferr; s_filt = n_filt;
    send(8'h41, 1'b0, -1, f0);
    step(4);
    chk("ferr_pulse", 32'(n_ferr - s_ferr), 32'd1);
    chk("ferr_align", 32'(ferr_cyc - f0), 32'(p));
    chk("ferr_no_push", 32'(rd_valid), 32'd0);
    chk("ferr_no_drop", 32'(n_filt - s_filt), 32'd0);

    // 3-tick glitch is a false start
    s_ferr = n_ferr; s_filt = n_filt; s_ovf = n_ovf;
    RsRx = 1'b0;
    step(6);
    RsRx = 1'b1;
    step(400);
    chk("glitch_valid", 32'(rd_valid), 32'd0);
    chk("glitch_pulses", 32'((n_ferr - s_ferr) + (n_filt - s_filt) + (n_ovf - s_ovf)), 32'd0);

    // Reset during data bit 4 with a byte already queued
    send(8'h42, 1'b1, -1, f0);
    step(4);
    chk("pre_reset_data", 32'(rd_data), 32'h42);
    partial = 8'h33;
    RsRx = 1'b0;
    step(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      RsRx = partial[i];
      step(BIT_CLKS);
    end
    RsRx = partial[4];
    step(BIT_CLKS / 2);
    rst_n = 1'b0;
    step(1);
    chk_reset_outputs("midreset");
    RsRx = 1'b1;
    rst_n = 1'b1;
    step(5);
    chk("midreset_no_push", 32'(rd_valid), 32'd0);
    send(8'h5A, 1'b1, -1, f0);
    step(4);
    chk("after_reset_valid", 32'(rd_valid), 32'd1);
    chk("after_reset_data", 32'(rd_data), 32'h5A);
    rd_ready = 1'b1;
    step(1);
    rd_ready = 1'b0;

    // 17 bytes into 16 entries
    s_ovf = n_ovf; s_filt = n_filt;
    for (int i = 0; i < 17; i++) send(8'h30, 1'b1, -1, f0);
    step(4);
    chk("ovf_pulse", 32'(n_ovf - s_ovf), 32'd1);
    chk("ovf_align", 32'(ovf_cyc - f0), 32'(p));
    chk("ovf_no_drop", 32'(n_filt - s_filt), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_pop%0d_valid", i), 32'(rd_valid), 32'd1);
      chk($sformatf("ovf_pop%0d_data", i), 32'(rd_data), 32'h30);
      rd_ready = 1'b1;
      step(1);
    end
    rd_ready = 1'b0;
    chk("ovf_drained", 32'(rd_valid), 32'd0);

    // Full FIFO, pop exactly in the push cycle of the next byte
    s_ovf = n_ovf;
    for (int i = 0; i < 16; i++) send(8'h41 + 8'(i), 1'b1, -1, f0);
    step(4);
    chk("full_head", 32'(rd_data), 32'h41);
    send(8'h61, 1'b1, p, f0);
    step(4);
    chk("full_pop_no_ovf", 32'(n_ovf - s_ovf), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("full_pop%0d_valid", i), 32'(rd_valid), 32'd1);
      chk($sformatf("full_pop%0d_data", i), 32'(rd_data), (i < 15) ? 32'h42 + 32'(i) : 32'h61);
      rd_ready = 1'b1;
      step(1);
    end
    rd_ready = 1'b0;
    chk("full_count_16", 32'(rd_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
